// File: rtl/ex_mdu_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes, FSM states
// and a small decode helper.
package ex_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6
  } md_op_e;

  typedef enum logic {
    MdIdle = 1'b0,
    MdBusy = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_muldiv(md_op_e op);
    return op inside {MdMult, MdMultu, MdDiv, MdDivu};
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: returns the HI/LO pair for mult/multu/div/divu
// and flags a divide by zero.
module mdu_arith
  import ex_mdu_ctrl_pkg::*;
(
  input  md_op_e      md_op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic [31:0] hi_res_o,
  output logic [31:0] lo_res_o,
  output logic        div_zero_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign div_zero_o = (md_op_i inside {MdDiv, MdDivu}) && (src_b_i == 32'd0);

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign divisor = (src_b_i == 32'd0) ? 32'd1 : src_b_i;

  assign prod_s = {{32{src_a_i[31]}}, src_a_i} * {{32{src_b_i[31]}}, src_b_i};
  assign prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};
  assign quot_s = $signed(src_a_i) / $signed(divisor);
  assign rem_s  = $signed(src_a_i) % $signed(divisor);
  assign quot_u = src_a_i / divisor;
  assign rem_u  = src_a_i % divisor;

  always_comb begin
    hi_res_o = 32'd0;
    lo_res_o = 32'd0;
    unique case (md_op_i)
      MdMult: begin
        hi_res_o = prod_s[63:32];
        lo_res_o = prod_s[31:0];
      end
      MdMultu: begin
        hi_res_o = prod_u[63:32];
        lo_res_o = prod_u[31:0];
      end
      MdDiv: begin
        hi_res_o = rem_s;
        lo_res_o = quot_s;
      end
      MdDivu: begin
        hi_res_o = rem_u;
        lo_res_o = quot_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// EX-stage multiply/divide sequencer: models the fixed latency with an IDLE/BUSY FSM and a
// down-counter, commits HI/LO at the end of the busy period and drives the hazard stall.
module ex_mdu_ctrl
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  md_op_e      md_op_i,
  input  logic        cancel_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic        busy_o,
  output logic        md_stall_o,
  output logic [31:0] hi_out_o,
  output logic [31:0] lo_out_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_zero;
  logic        accept;

  mdu_arith u_arith (
    .md_op_i    (md_op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .hi_res_o   (hi_res),
    .lo_res_o   (lo_res),
    .div_zero_o (div_zero)
  );

  assign accept = start_i && !cancel_i && (state_q == MdIdle);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= MdIdle;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      MdIdle: begin
        if (accept) begin
          if (is_muldiv(md_op_i)) begin
            state_d   = MdBusy;
            cnt_d     = (md_op_i inside {MdMult, MdMultu}) ? CntW'(MULT_CYCLES)
                                                          : CntW'(DIV_CYCLES);
            pend_hi_d = hi_res;
            pend_lo_d = lo_res;
            pend_wr_d = !div_zero;
          end else if (md_op_i == MdMthi) begin
            hi_d = src_a_i;
          end else if (md_op_i == MdMtlo) begin
            lo_d = src_a_i;
          end
        end
      end
      MdBusy: begin
        if (cnt_q == CntW'(1)) begin
          state_d = MdIdle;
          cnt_d   = '0;
          // Divide by zero still burns the full latency but leaves HI/LO untouched.
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == MdBusy);
    md_stall_o = busy_o || (start_i && !cancel_i && is_muldiv(md_op_i));
    hi_out_o   = hi_q;
    lo_out_o   = lo_q;
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Scoreboard bench for ex_mdu_ctrl: stimulus pushes expected commits, a negedge monitor
// pops and compares them when busy falls.
module tb_ex_mdu_ctrl;
  import ex_mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  md_op_e      md_op;
  logic        cancel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  ex_mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .md_op_i    (md_op),
    .cancel_i   (cancel),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .busy_o     (busy),
    .md_stall_o (md_stall),
    .hi_out_o   (hi_out),
    .lo_out_o   (lo_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, compare HI/LO in the first cycle busy is low again.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_commit: got hi=%08h lo=%08h expected no commit",
                   hi_out, lo_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("commit_hi", hi_out, mon_e.hi);
          check("commit_lo", lo_out, mon_e.lo);
          check("busy_cycles", 32'(busy_cnt), 32'(mon_e.cycles));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    start  = 1'b1;
    md_op  = op;
    src_a  = a;
    src_b  = b;
    cancel = c;
  endtask

  task automatic release_in();
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    md_op  = MdNone;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    drive(op, a, b, c);
    release_in();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected busy=0", k);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    md_op  = MdNone;
    src_a  = 32'd0;
    src_b  = 32'd0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);
    check("reset_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // mult signed: -2 * 3
    sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    issue(MdMult, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check("mult_busy_after_accept", 32'(busy), 32'd1);
    wait_idle();

    // multu: stall is combinational in the start cycle
    sb_q.push_back('{32'h0000_0002, 32'hFFFF_FFFA, 5});
    drive(MdMultu, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    #1;
    check("multu_start_stall", 32'(md_stall), 32'd1);
    check("multu_start_busy", 32'(busy), 32'd0);
    release_in();
    wait_idle();

    // div -7 / 2; old HI/LO held during busy
    sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    issue(MdDiv, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("div_midbusy_hi", hi_out, 32'h0000_0002);
    check("div_midbusy_lo", lo_out, 32'hFFFF_FFFA);
    wait_idle();

    // mthi/mtlo then divu by zero
    issue(MdMthi, 32'h0000_1234, 32'd0, 1'b0);
    check("mthi_hi", hi_out, 32'h0000_1234);
    check("mthi_busy", 32'(busy), 32'd0);
    issue(MdMtlo, 32'h0000_5678, 32'd0, 1'b0);
    check("mtlo_lo", lo_out, 32'h0000_5678);
    check("mtlo_hi_kept", hi_out, 32'h0000_1234);
    sb_q.push_back('{32'h0000_1234, 32'h0000_5678, 10});
    issue(MdDivu, 32'h0000_DEAD, 32'd0, 1'b0);
    wait_idle();

    // MD_NONE start has no effect
    drive(MdNone, 32'hFFFF_FFFF, 32'h1, 1'b0);
    #1;
    check("none_stall", 32'(md_stall), 32'd0);
    release_in();
    check("none_busy", 32'(busy), 32'd0);
    check("none_hi", hi_out, 32'h0000_1234);

    // cancelled mult is ignored
    drive(MdMult, 32'd5, 32'd7, 1'b1);
    #1;
    check("cancel_stall", 32'(md_stall), 32'd0);
    release_in();
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_hi", hi_out, 32'h0000_1234);
    check("cancel_lo", lo_out, 32'h0000_5678);

    // valid mult, divu in busy cycle 2 ignored
    sb_q.push_back('{32'h0000_0001, 32'h0000_0000, 5});
    issue(MdMult, 32'h0001_0000, 32'h0001_0000, 1'b0);
    @(posedge clk);
    #1;
    drive(MdDivu, 32'd100, 32'd7, 1'b0);
    #1;
    check("busy_start_stall", 32'(md_stall), 32'd1);
    release_in();
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_divu_busy", 32'(busy), 32'd0);
    check("ignored_divu_hi", hi_out, 32'h0000_0001);

    // async reset mid-busy discards the pending div
    issue(MdDiv, 32'd100, 32'd3, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_hi", hi_out, 32'd0);
    check("async_reset_lo", lo_out, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_hi", hi_out, 32'd0);
    check("post_reset_lo", lo_out, 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
